// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
// Contents: FSM state encoding, default byte width, clog2 helper.
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] LOCKED    = 2'b01;
  localparam logic [1:0] START     = 2'b10;
  localparam logic [1:0] WAIT_DONE = 2'b11;

  // Bits needed to hold 0..n-1; never less than 1 so single-bit fields stay legal.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin search.
// Ports:
//   req     - request vector
//   rr_ptr  - index of the previous winner; search starts at rr_ptr+1
//   grant   - index of the first set request found (0 when none)
//   any_req - at least one request bit is set
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    // Offsets 1..NUM_REQ so the previous winner is checked last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(rr_ptr) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX core between NUM_REQ byte-stream requesters with
// round-robin arbitration and packet locking.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   req_valid/data/last   - per-requester byte stream (requester i at [i*DATA_W +: DATA_W])
//   req_ready             - per-requester accept, at most one bit high
//   tx_start, tx_data     - frame launch pulse and byte to the transmitter
//   tx_busy, tx_done      - transmitter status / end-of-frame pulse
//   grant_id, active      - current or last owner, packet locked
//   timeout_err           - sticky, set when a stalled packet is force-released
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  localparam int unsigned IDX_W = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int unsigned CNT_W = clog2(LOCK_TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              active_q, active_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  arb_grant;
  logic              arb_any;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              sel_valid;
  logic              handshake;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  // Mux out the owner's byte stream.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_last  = req_last[i];
        sel_valid = req_valid[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == LOCKED && !tx_busy) req_ready[grant_q] = 1'b1;
  end

  assign handshake = (state_q == LOCKED) && !tx_busy && sel_valid;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    active_d = active_q;
    err_d    = err_q;
    data_d   = data_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d  = arb_grant;
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (handshake) begin
          data_d  = sel_data;
          last_d  = sel_last;
          cnt_d   = '0;
          state_d = START;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          // Owner stalled too long: release so others are not starved.
          err_d    = 1'b1;
          active_d = 1'b0;
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          if (last_q) begin
            active_d = 1'b0;
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end else begin
            state_d = LOCKED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      active_q <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      active_q <= active_d;
      err_q    <= err_d;
      data_q   <= data_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tx_start    = (state_q == START);
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (NUM_REQ=4, DATA_W=8, LOCK_TIMEOUT=16).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .LOCK_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Transmitter model: waits (bounded) for tx_start, records the frame, then
  // signals tx_done delay cycles later. Returns at the negedge after tx_done.
  task automatic serve_frame(input int delay, input logic [3:0] clr, output logic found,
                             output logic [7:0] data, output logic [1:0] gid,
                             output logic [3:0] rdy_or);
    found  = 1'b0;
    data   = '0;
    gid    = '0;
    rdy_or = '0;
    for (int i = 0; i < 100; i++) begin
      rdy_or |= req_ready;
      if (tx_start) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) return;
    data      = tx_data;
    gid       = grant_id;
    req_valid = req_valid & ~clr;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (delay - 2) begin
      rdy_or |= req_ready;
      @(negedge clk);
    end
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    n_checks++;
    if ({tx_start, active, timeout_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {tx_start, active, timeout_err});
    end
    n_checks++;
    if ({grant_id, tx_data} !== 10'h000) begin
      n_fail++; $display("FAIL reset_regs: got %h expected 000", {grant_id, tx_data});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (active !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_grant: got %b expected 0", active);
    end
  endtask

  task automatic test_single_packet();
    logic f; logic [7:0] d; logic [1:0] g; logic [3:0] r;
    do_reset();
    req_data  = 32'h0000_00A5;
    req_last  = 4'b0000;
    req_valid = 4'b0001;
    serve_frame(160, 4'b0000, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'hA5 || g !== 2'd0) begin
      n_fail++; $display("FAIL single_byte0: got f=%b d=%h g=%0d expected f=1 d=a5 g=0", f, d, g);
    end
    n_checks++;
    if (active !== 1'b1 || req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL single_relock: got active=%b ready=%b expected 1 0001", active, req_ready);
    end
    req_data = 32'h0000_003C;
    req_last = 4'b0001;
    serve_frame(160, 4'b0001, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h3C || g !== 2'd0) begin
      n_fail++; $display("FAIL single_byte1: got f=%b d=%h g=%0d expected f=1 d=3c g=0", f, d, g);
    end
    n_checks++;
    if (active !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h3C) begin
      n_fail++; $display("FAIL single_end: got active=%b g=%0d data=%h expected 0 0 3c",
                         active, grant_id, tx_data);
    end
  endtask

  task automatic test_fairness();
    logic f; logic [7:0] d; logic [1:0] g; logic [3:0] r;
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [7:0] exp_d [6] = '{8'h11, 8'h22, 8'h44, 8'h11, 8'h22, 8'h44};
    do_reset();
    req_data  = 32'h4433_2211;
    req_last  = 4'b1111;
    req_valid = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      serve_frame(20, (k == 5) ? 4'b1011 : 4'b0000, f, d, g, r);
      n_checks++;
      if (f !== 1'b1 || g !== exp_g[k] || d !== exp_d[k] || r[2] !== 1'b0) begin
        n_fail++; $display("FAIL fair_%0d: got f=%b g=%0d d=%h r2=%b expected f=1 g=%0d d=%h r2=0",
                           k, f, g, d, r[2], exp_g[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_packet_lock();
    logic f; logic [7:0] d; logic [1:0] g; logic [3:0] r;
    do_reset();
    req_data  = 32'h0000_5066;
    req_last  = 4'b0001;
    req_valid = 4'b0010;
    serve_frame(20, 4'b0000, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h50 || g !== 2'd1) begin
      n_fail++; $display("FAIL lock_first: got f=%b d=%h g=%0d expected f=1 d=50 g=1", f, d, g);
    end
    req_data  = 32'h0000_5566;
    req_last  = 4'b0011;
    req_valid = 4'b0011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL lock_ready: got %b expected 0010", req_ready);
    end
    serve_frame(20, 4'b0010, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h55 || g !== 2'd1 || r[0] !== 1'b0) begin
      n_fail++; $display("FAIL lock_second: got f=%b d=%h g=%0d r0=%b expected f=1 d=55 g=1 r0=0",
                         f, d, g, r[0]);
    end
    serve_frame(20, 4'b0001, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h66 || g !== 2'd0) begin
      n_fail++; $display("FAIL lock_next: got f=%b d=%h g=%0d expected f=1 d=66 g=0", f, d, g);
    end
  endtask

  task automatic test_busy_gating();
    logic bad;
    do_reset();
    tx_busy   = 1'b1;
    req_data  = 32'h0000_0099;
    req_last  = 4'b0001;
    req_valid = 4'b0001;
    @(negedge clk);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (req_ready !== 4'b0000 || tx_start !== 1'b0 || active !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL busy_block: got violation=%b expected 0", bad);
    end
    tx_busy = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL busy_release_ready: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h99) begin
      n_fail++; $display("FAIL busy_start: got start=%b data=%h expected 1 99", tx_start, tx_data);
    end
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b0) begin
      n_fail++; $display("FAIL busy_pulse_width: got %b expected 0", tx_start);
    end
  endtask

  task automatic test_timeout();
    logic f; logic [7:0] d; logic [1:0] g; logic [3:0] r;
    logic bad;
    do_reset();
    req_data  = 32'h8877_0000;
    req_last  = 4'b1000;
    req_valid = 4'b1100;
    serve_frame(20, 4'b0100, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h77 || g !== 2'd2) begin
      n_fail++; $display("FAIL to_first: got f=%b d=%h g=%0d expected f=1 d=77 g=2", f, d, g);
    end
    bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (timeout_err !== 1'b0 || active !== 1'b1 || req_ready[3] !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL to_early: got early release=%b expected 0", bad);
    end
    n_checks++;
    if (timeout_err !== 1'b1 || active !== 1'b0) begin
      n_fail++; $display("FAIL to_fire: got err=%b active=%b expected 1 0", timeout_err, active);
    end
    serve_frame(20, 4'b1000, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h88 || g !== 2'd3 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL to_next: got f=%b d=%h g=%0d err=%b expected f=1 d=88 g=3 err=1",
                         f, d, g, timeout_err);
    end
  endtask

  // Runs straight after test_timeout so timeout_err is set going in.
  task automatic test_reset_mid_frame();
    logic f; logic [7:0] d; logic [1:0] g; logic [3:0] r;
    logic bad;
    req_data  = 32'h0000_C30F;
    req_last  = 4'b0011;
    req_valid = 4'b0010;
    f = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_start) begin
        f = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    tx_busy   = 1'b1;
    n_checks++;
    if (f !== 1'b1 || active !== 1'b1 || grant_id !== 2'd1 || timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: got f=%b active=%b g=%0d err=%b expected 1 1 1 1",
                         f, active, grant_id, timeout_err);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, tx_start, active, timeout_err} !== 7'b0) begin
      n_fail++; $display("FAIL rst_async_flags: got %b expected 0000000",
                         {req_ready, tx_start, active, timeout_err});
    end
    n_checks++;
    if ({grant_id, tx_data} !== 10'h000) begin
      n_fail++; $display("FAIL rst_async_regs: got %h expected 000", {grant_id, tx_data});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tx_busy = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (tx_start !== 1'b0 || active !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale_done: got spurious activity=%b expected 0", bad);
    end
    req_valid = 4'b0011;
    serve_frame(20, 4'b0011, f, d, g, r);
    n_checks++;
    if (f !== 1'b1 || d !== 8'h0F || g !== 2'd0) begin
      n_fail++; $display("FAIL rst_first_grant: got f=%b d=%h g=%0d expected f=1 d=0f g=0", f, d, g);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_fairness();
    test_packet_lock();
    test_busy_gating();
    test_timeout();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
